// File: rtl/line_age_tracker.sv
// Per-set, per-way valid/age bookkeeping feeding the replacement selector.
// Larger age means older; a touched way drops to age 0, other valid ways in
// the same set age by one (saturating). One update and one lookup per cycle.
//
// Handshake: there is no backpressure. While ready is high, an update is
// taken on every clock edge where upd_valid is high, and a lookup on every
// edge where lookup_valid is high. Its result appears one cycle later with
// out_valid high for exactly that cycle. While ready is low (set-clearing
// after reset) both request strobes are ignored.
module line_age_tracker #(
  parameter int N_WAYS   = 2,
  parameter int N_POW    = 4,
  parameter int N_SETS   = 16,
  parameter int SET_BITS = 4,
  parameter int AGE_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  output logic                ready,
  input  logic                upd_valid,
  input  logic [1:0]          upd_op,
  input  logic [SET_BITS-1:0] upd_set,
  input  logic [N_POW-1:0]    upd_way,
  output logic                upd_err,
  input  logic                lookup_valid,
  input  logic [SET_BITS-1:0] lookup_set,
  output logic                out_valid,
  output logic                line_empty [N_WAYS],
  output logic [31:0]         line_age [N_WAYS]
);

  localparam logic [1:0] OP_ACCESS = 2'b01;
  localparam logic [1:0] OP_FILL   = 2'b10;
  localparam logic [1:0] OP_INVAL  = 2'b11;

  localparam logic [AGE_W-1:0]    AGE_MAX  = '1;
  localparam logic [SET_BITS-1:0] LAST_SET = SET_BITS'(N_SETS - 1);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [SET_BITS-1:0] cnt_q, cnt_d;
  logic                init_clr;

  // Line state, one row per set.
  logic                valid_q [N_SETS][N_WAYS];
  logic [AGE_W-1:0]    age_q   [N_SETS][N_WAYS];

  // Update datapath.
  logic                set_ok;
  logic                way_ok;
  logic [SET_BITS-1:0] rd_set;
  logic                upd_act;
  logic                upd_we;
  logic                err_d;
  logic                tgt_valid;
  logic                sel       [N_WAYS];
  logic                cur_valid [N_WAYS];
  logic [AGE_W-1:0]    cur_age   [N_WAYS];
  logic                nxt_valid [N_WAYS];
  logic [AGE_W-1:0]    nxt_age   [N_WAYS];

  // Lookup datapath.
  logic                byp;
  logic                rd_valid  [N_WAYS];
  logic [AGE_W-1:0]    rd_age    [N_WAYS];

  // Index range checks; a full power-of-two set count needs no check.
  if (N_SETS >= (1 << SET_BITS)) begin : g_set_full
    assign set_ok = 1'b1;
  end else begin : g_set_chk
    assign set_ok = (int'(upd_set) < N_SETS);
  end

  if (N_WAYS >= (1 << N_POW)) begin : g_way_full
    assign way_ok = 1'b1;
  end else begin : g_way_chk
    assign way_ok = (int'(upd_way) < N_WAYS);
  end

  assign ready = (state_q == S_RUN);

  // FSM state register and set-clear counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state: INIT clears one set per cycle, then RUN forever.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    init_clr = 1'b0;
    case (state_q)
      S_INIT: begin
        init_clr = 1'b1;
        cnt_d    = cnt_q + SET_BITS'(1);
        if (cnt_q == LAST_SET) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = S_INIT;
    endcase
  end

  // Decode the update and build the new row for the target set.
  always_comb begin
    rd_set    = set_ok ? upd_set : '0;
    upd_act   = ready && !rst && upd_valid && (upd_op != 2'b00);
    upd_we    = 1'b0;
    err_d     = 1'b0;
    tgt_valid = 1'b0;
    for (int w = 0; w < N_WAYS; w++) begin
      sel[w]       = (upd_way == N_POW'(w));
      cur_valid[w] = valid_q[rd_set][w];
      cur_age[w]   = age_q[rd_set][w];
      nxt_valid[w] = cur_valid[w];
      nxt_age[w]   = cur_age[w];
      if (sel[w] && cur_valid[w]) tgt_valid = 1'b1;
    end
    if (upd_act) begin
      if (!set_ok || !way_ok) begin
        err_d = 1'b1;
      end else begin
        case (upd_op)
          OP_ACCESS: begin
            if (!tgt_valid) begin
              err_d = 1'b1;
            end else begin
              upd_we = 1'b1;
              for (int w = 0; w < N_WAYS; w++) begin
                if (sel[w])            nxt_age[w] = '0;
                else if (cur_valid[w]) nxt_age[w] = (cur_age[w] == AGE_MAX) ? cur_age[w] : cur_age[w] + AGE_W'(1);
              end
            end
          end
          OP_FILL: begin
            upd_we = 1'b1;
            for (int w = 0; w < N_WAYS; w++) begin
              if (sel[w]) begin
                nxt_valid[w] = 1'b1;
                nxt_age[w]   = '0;
              end else if (cur_valid[w]) begin
                nxt_age[w] = (cur_age[w] == AGE_MAX) ? cur_age[w] : cur_age[w] + AGE_W'(1);
              end
            end
          end
          OP_INVAL: begin
            upd_we = 1'b1;
            for (int w = 0; w < N_WAYS; w++) begin
              if (sel[w]) begin
                nxt_valid[w] = 1'b0;
                nxt_age[w]   = '0;
              end
            end
          end
          default: upd_we = 1'b0;
        endcase
      end
    end
  end

  // Line state storage: set clearing during INIT, row write-back in RUN.
  always_ff @(posedge clk) begin
    if (init_clr) begin
      for (int w = 0; w < N_WAYS; w++) begin
        valid_q[cnt_q][w] <= 1'b0;
        age_q[cnt_q][w]   <= '0;
      end
    end else if (upd_we) begin
      for (int w = 0; w < N_WAYS; w++) begin
        valid_q[upd_set][w] <= nxt_valid[w];
        age_q[upd_set][w]   <= nxt_age[w];
      end
    end
  end

  // Lookup read with write-first forwarding from a same-set update.
  always_comb begin
    byp = upd_we && (lookup_set == upd_set);
    for (int w = 0; w < N_WAYS; w++) begin
      rd_valid[w] = byp ? nxt_valid[w] : valid_q[lookup_set][w];
      rd_age[w]   = byp ? nxt_age[w]   : age_q[lookup_set][w];
    end
  end

  // Registered outputs: result holds when no lookup is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      upd_err   <= 1'b0;
      for (int w = 0; w < N_WAYS; w++) begin
        line_empty[w] <= 1'b1;
        line_age[w]   <= '0;
      end
    end else begin
      upd_err   <= err_d;
      out_valid <= ready && lookup_valid;
      if (ready && lookup_valid) begin
        for (int w = 0; w < N_WAYS; w++) begin
          line_empty[w] <= !rd_valid[w];
          line_age[w]   <= 32'(rd_age[w]);
        end
      end
    end
  end

endmodule
